// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
package mem_arb_pkg;

    // Transaction FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    // Memory function codes
    localparam logic FCN_RD = 1'b0;
    localparam logic FCN_WR = 1'b1;

    // Owner / grant identifiers
    localparam logic OWNER_M0 = 1'b0;
    localparam logic OWNER_M1 = 1'b1;

    // Width of the saturating response-timeout counter
    localparam int unsigned CNT_W = 8;

    // Request fields captured at accept time and replayed to memory
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        fcn;
        logic [2:0]  typ;
    } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-input round-robin grant logic with its last-grant history flop.
// Grants are combinational from the requests; history advances only on accept.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic req0_i,
    input  logic req1_i,
    input  logic accept_i,
    output logic gnt0_o,
    output logic gnt1_o
);

    logic last_q;
    logic last_d;

    // Grant selection: a lone requester wins, contention goes to the one not served last
    always_comb begin
        gnt0_o = 1'b0;
        gnt1_o = 1'b0;
        if (req0_i && req1_i) begin
            if (last_q == OWNER_M1) begin
                gnt0_o = 1'b1;
            end else begin
                gnt1_o = 1'b1;
            end
        end else if (req0_i) begin
            gnt0_o = 1'b1;
        end else if (req1_i) begin
            gnt1_o = 1'b1;
        end
    end

    // History update: remember who was granted when a request is actually accepted
    always_comb begin
        last_d = last_q;
        if (accept_i && (gnt0_o || gnt1_o)) begin
            last_d = gnt1_o ? OWNER_M1 : OWNER_M0;
        end
    end

    // History register; resets to m1 so m0 wins the first contention
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q <= OWNER_M1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: shares one on-chip memory port between two requesters
// with round-robin arbitration, one outstanding transaction and a response timeout.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_req_valid,
    output logic        m0_req_ready,
    input  logic [31:0] m0_req_addr,
    input  logic [31:0] m0_req_data,
    input  logic        m0_req_fcn,
    input  logic [2:0]  m0_req_typ,
    output logic        m0_resp_valid,
    output logic [31:0] m0_resp_data,

    input  logic        m1_req_valid,
    output logic        m1_req_ready,
    input  logic [31:0] m1_req_addr,
    input  logic [31:0] m1_req_data,
    input  logic        m1_req_fcn,
    input  logic [2:0]  m1_req_typ,
    output logic        m1_resp_valid,
    output logic [31:0] m1_resp_data,

    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    output logic [31:0] mem_req_data,
    output logic        mem_req_fcn,
    output logic [2:0]  mem_req_typ,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,

    output logic        bus_err
);

    // Counter value in the last WAIT cycle before a timeout response is produced
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    state_e           state_q, state_d;
    mem_req_t         req_q, req_d;
    logic             owner_q, owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             m0_rv_q, m0_rv_d;
    logic             m1_rv_q, m1_rv_d;
    logic [31:0]      m0_rd_q, m0_rd_d;
    logic [31:0]      m1_rd_q, m1_rd_d;
    logic             err_q, err_d;

    logic gnt0;
    logic gnt1;
    logic idle;
    logic accept;
    logic timeout_hit;

    assign idle        = (state_q == ST_IDLE);
    assign accept      = idle && (gnt0 || gnt1);
    assign timeout_hit = (cnt_q == TO_LAST);

    rr_arb2 u_rr_arb2 (
        .clk_i    (clk),
        .rst_i    (rst),
        .req0_i   (m0_req_valid),
        .req1_i   (m1_req_valid),
        .accept_i (accept),
        .gnt0_o   (gnt0),
        .gnt1_o   (gnt1)
    );

    assign m0_req_ready = idle && gnt0;
    assign m1_req_ready = idle && gnt1;

    assign mem_req_valid = (state_q == ST_ISSUE);
    assign mem_req_addr  = req_q.addr;
    assign mem_req_data  = req_q.data;
    assign mem_req_fcn   = req_q.fcn;
    assign mem_req_typ   = req_q.typ;

    assign m0_resp_valid = m0_rv_q;
    assign m0_resp_data  = m0_rd_q;
    assign m1_resp_valid = m1_rv_q;
    assign m1_resp_data  = m1_rd_q;
    assign bus_err       = err_q;

    // Next-state logic: FSM transitions, request capture, timeout count and response pulses
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        m0_rv_d = 1'b0;
        m1_rv_d = 1'b0;
        m0_rd_d = '0;
        m1_rd_d = '0;
        err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (gnt1) begin
                        req_d   = '{addr: m1_req_addr, data: m1_req_data,
                                    fcn: m1_req_fcn, typ: m1_req_typ};
                        owner_d = OWNER_M1;
                    end else begin
                        req_d   = '{addr: m0_req_addr, data: m0_req_data,
                                    fcn: m0_req_fcn, typ: m0_req_typ};
                        owner_d = OWNER_M0;
                    end
                    state_d = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                if (mem_req_ready) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
                // A real response takes priority over a timeout in the same cycle
                if (mem_resp_valid) begin
                    if (owner_q == OWNER_M1) begin
                        m1_rv_d = 1'b1;
                        m1_rd_d = mem_resp_data;
                    end else begin
                        m0_rv_d = 1'b1;
                        m0_rd_d = mem_resp_data;
                    end
                    state_d = ST_IDLE;
                end else if (timeout_hit) begin
                    if (owner_q == OWNER_M1) begin
                        m1_rv_d = 1'b1;
                    end else begin
                        m0_rv_d = 1'b1;
                    end
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            req_q   <= '0;
            owner_q <= OWNER_M0;
            cnt_q   <= '0;
            m0_rv_q <= 1'b0;
            m1_rv_q <= 1'b0;
            m0_rd_q <= '0;
            m1_rd_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            m0_rv_q <= m0_rv_d;
            m1_rv_q <= m1_rv_d;
            m0_rd_q <= m0_rd_d;
            m1_rd_q <= m1_rd_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
module tb_mem_port_arbiter;

    localparam int unsigned TO = 16;

    logic        clk;
    logic        rst;
    logic        m0_req_valid, m0_req_ready, m0_req_fcn, m0_resp_valid;
    logic [31:0] m0_req_addr, m0_req_data, m0_resp_data;
    logic [2:0]  m0_req_typ;
    logic        m1_req_valid, m1_req_ready, m1_req_fcn, m1_resp_valid;
    logic [31:0] m1_req_addr, m1_req_data, m1_resp_data;
    logic [2:0]  m1_req_typ;
    logic        mem_req_valid, mem_req_ready, mem_req_fcn, mem_resp_valid;
    logic [31:0] mem_req_addr, mem_req_data, mem_resp_data;
    logic [2:0]  mem_req_typ;
    logic        bus_err;

    int total;
    int passed;

    mem_port_arbiter #(.TIMEOUT(TO)) dut (
        .clk            (clk),
        .rst            (rst),
        .m0_req_valid   (m0_req_valid),
        .m0_req_ready   (m0_req_ready),
        .m0_req_addr    (m0_req_addr),
        .m0_req_data    (m0_req_data),
        .m0_req_fcn     (m0_req_fcn),
        .m0_req_typ     (m0_req_typ),
        .m0_resp_valid  (m0_resp_valid),
        .m0_resp_data   (m0_resp_data),
        .m1_req_valid   (m1_req_valid),
        .m1_req_ready   (m1_req_ready),
        .m1_req_addr    (m1_req_addr),
        .m1_req_data    (m1_req_data),
        .m1_req_fcn     (m1_req_fcn),
        .m1_req_typ     (m1_req_typ),
        .m1_resp_valid  (m1_resp_valid),
        .m1_resp_data   (m1_resp_data),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_req_data   (mem_req_data),
        .mem_req_fcn    (mem_req_fcn),
        .mem_req_typ    (mem_req_typ),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .bus_err        (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        total  = 0;
        passed = 0;
        rst = 1'b1;
        m0_req_valid = 0; m0_req_addr = '0; m0_req_data = '0; m0_req_fcn = 0; m0_req_typ = '0;
        m1_req_valid = 0; m1_req_addr = '0; m1_req_data = '0; m1_req_fcn = 0; m1_req_typ = '0;
        mem_req_ready = 1'b1; mem_resp_valid = 1'b0; mem_resp_data = '0;

        // Reset state
        tick(); tick();
        chk("rst_mem_valid", mem_req_valid, 0);
        chk("rst_mem_addr", mem_req_addr, 0);
        chk("rst_m0_rv", m0_resp_valid, 0);
        chk("rst_m1_rv", m1_resp_valid, 0);
        chk("rst_m0_rd", m0_resp_data, 0);
        chk("rst_bus_err", bus_err, 0);
        rst = 1'b0;

        // Single read from m0, minimum latency
        m0_req_valid = 1; m0_req_addr = 32'h0000_0010; m0_req_fcn = 0; m0_req_typ = 3'b010;
        #1;
        chk("rd_m0_ready", m0_req_ready, 1);
        chk("rd_m1_ready", m1_req_ready, 0);
        tick();
        m0_req_valid = 0;
        chk("rd_mem_valid", mem_req_valid, 1);
        chk("rd_mem_addr", mem_req_addr, 32'h10);
        chk("rd_mem_fcn", mem_req_fcn, 0);
        chk("rd_mem_typ", mem_req_typ, 3'b010);
        chk("rd_m0_ready_busy", m0_req_ready, 0);
        tick();
        chk("rd_wait_valid", mem_req_valid, 0);
        mem_resp_valid = 1; mem_resp_data = 32'hDEAD_BEEF;
        tick();
        mem_resp_valid = 0;
        chk("rd_m0_rv", m0_resp_valid, 1);
        chk("rd_m0_rd", m0_resp_data, 32'hDEAD_BEEF);
        chk("rd_m1_rv", m1_resp_valid, 0);
        chk("rd_m1_rd", m1_resp_data, 0);
        chk("rd_bus_err", bus_err, 0);
        tick();
        chk("rd_m0_rv_pulse", m0_resp_valid, 0);

        // Contention from reset: m0, m1, m0
        rst = 1; #2; rst = 0;
        m0_req_valid = 1; m0_req_addr = 32'h100; m0_req_fcn = 0; m0_req_typ = 3'b000;
        m1_req_valid = 1; m1_req_addr = 32'h200; m1_req_data = 32'h55AA; m1_req_fcn = 1; m1_req_typ = 3'b001;
        #1;
        chk("ct1_m0_ready", m0_req_ready, 1);
        chk("ct1_m1_ready", m1_req_ready, 0);
        tick();
        chk("ct1_addr", mem_req_addr, 32'h100);
        chk("ct1_busy_m0", m0_req_ready, 0);
        chk("ct1_busy_m1", m1_req_ready, 0);
        tick();
        mem_resp_valid = 1; mem_resp_data = 32'h1111_0000;
        tick();
        mem_resp_valid = 0;
        chk("ct1_m0_rv", m0_resp_valid, 1);
        chk("ct1_m0_rd", m0_resp_data, 32'h1111_0000);
        chk("ct1_m1_rv", m1_resp_valid, 0);
        chk("ct2_m1_ready", m1_req_ready, 1);
        chk("ct2_m0_ready", m0_req_ready, 0);
        tick();
        chk("ct2_addr", mem_req_addr, 32'h200);
        chk("ct2_fcn", mem_req_fcn, 1);
        chk("ct2_data", mem_req_data, 32'h55AA);
        chk("ct2_typ", mem_req_typ, 3'b001);
        chk("ct2_m0_rv", m0_resp_valid, 0);
        tick();
        mem_resp_valid = 1; mem_resp_data = 32'h2222_0000;
        tick();
        mem_resp_valid = 0;
        chk("ct2_m1_rv", m1_resp_valid, 1);
        chk("ct2_m1_rd", m1_resp_data, 32'h2222_0000);
        chk("ct2_m0_rv", m0_resp_valid, 0);
        chk("ct3_m0_ready", m0_req_ready, 1);
        chk("ct3_m1_ready", m1_req_ready, 0);
        tick();
        m0_req_valid = 0; m1_req_valid = 0;
        chk("ct3_addr", mem_req_addr, 32'h100);
        tick();
        mem_resp_valid = 1; mem_resp_data = 32'h3333_0000;
        tick();
        mem_resp_valid = 0;
        chk("ct3_m0_rv", m0_resp_valid, 1);
        chk("ct3_m0_rd", m0_resp_data, 32'h3333_0000);
        chk("ct3_m1_rv", m1_resp_valid, 0);
        tick();
        chk("ct3_m0_rv_pulse", m0_resp_valid, 0);
        chk("ct3_m1_rv_pulse", m1_resp_valid, 0);

        // Backpressure: ready low 5 cycles, fields held, spurious response in ISSUE ignored
        m1_req_valid = 1; m1_req_addr = 32'h300; m1_req_fcn = 0; m1_req_typ = 3'b100;
        mem_req_ready = 0;
        #1;
        chk("bp_m1_ready", m1_req_ready, 1);
        tick();
        m1_req_valid = 0; m1_req_addr = 32'hFFFF_FFFF;
        for (int i = 0; i < 6; i++) begin
            chk("bp_mem_valid", mem_req_valid, 1);
            chk("bp_mem_addr", mem_req_addr, 32'h300);
            chk("bp_mem_typ", mem_req_typ, 3'b100);
            chk("bp_m1_rv", m1_resp_valid, 0);
            mem_resp_valid = (i == 2);
            mem_req_ready  = (i == 5);
            tick();
        end
        mem_resp_valid = 0;
        chk("bp_wait_valid", mem_req_valid, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_wait_rv", m1_resp_valid, 0);
            chk("bp_wait_err", bus_err, 0);
        end
        mem_resp_valid = 1; mem_resp_data = 32'h4444_0000;
        tick();
        mem_resp_valid = 0;
        chk("bp_m1_rv", m1_resp_valid, 1);
        chk("bp_m1_rd", m1_resp_data, 32'h4444_0000);
        chk("bp_bus_err", bus_err, 0);
        tick();

        // Timeout on m1: response exactly TO cycles after entering WAIT
        m1_req_valid = 1; m1_req_addr = 32'h400;
        tick();
        m1_req_valid = 0;
        tick();
        for (int i = 1; i < int'(TO); i++) begin
            tick();
            chk("to_early_rv", m1_resp_valid, 0);
        end
        tick();
        chk("to_m1_rv", m1_resp_valid, 1);
        chk("to_m1_rd", m1_resp_data, 0);
        chk("to_bus_err", bus_err, 1);
        chk("to_m0_rv", m0_resp_valid, 0);
        tick();
        chk("to_err_pulse", bus_err, 0);
        chk("to_rv_pulse", m1_resp_valid, 0);

        // Response coinciding with timeout cycle wins
        m0_req_valid = 1; m0_req_addr = 32'h500;
        tick();
        m0_req_valid = 0;
        tick();
        for (int i = 1; i < int'(TO); i++) tick();
        mem_resp_valid = 1; mem_resp_data = 32'hCAFE_F00D;
        tick();
        mem_resp_valid = 0;
        chk("co_m0_rv", m0_resp_valid, 1);
        chk("co_m0_rd", m0_resp_data, 32'hCAFE_F00D);
        chk("co_bus_err", bus_err, 0);

        // Spurious response while IDLE
        mem_resp_valid = 1; mem_resp_data = 32'h9999_9999;
        tick();
        mem_resp_valid = 0;
        chk("sp_m0_rv", m0_resp_valid, 0);
        chk("sp_m1_rv", m1_resp_valid, 0);
        chk("sp_mem_valid", mem_req_valid, 0);
        tick();
        chk("sp_m0_rv2", m0_resp_valid, 0);
        chk("sp_m1_rv2", m1_resp_valid, 0);

        // Reset in WAIT: abandon, then m1 granted alone
        m0_req_valid = 1; m0_req_addr = 32'h600; m0_req_data = 32'h77; m0_req_fcn = 1;
        tick();
        m0_req_valid = 0;
        tick();
        tick();
        rst = 1;
        #1;
        chk("rw_mem_valid", mem_req_valid, 0);
        chk("rw_mem_addr", mem_req_addr, 0);
        chk("rw_mem_data", mem_req_data, 0);
        chk("rw_mem_fcn", mem_req_fcn, 0);
        chk("rw_m0_rv", m0_resp_valid, 0);
        chk("rw_bus_err", bus_err, 0);
        mem_resp_valid = 1; mem_resp_data = 32'h1234_5678;
        tick();
        rst = 0; mem_resp_valid = 0;
        chk("rw_m0_rv_rst", m0_resp_valid, 0);
        tick();
        chk("rw_m0_rv_after", m0_resp_valid, 0);
        m1_req_valid = 1; m1_req_addr = 32'h700; m1_req_fcn = 0;
        #1;
        chk("rw_m1_ready", m1_req_ready, 1);
        chk("rw_m0_ready", m0_req_ready, 0);
        tick();
        m1_req_valid = 0;
        chk("rw_addr", mem_req_addr, 32'h700);
        tick();
        mem_resp_valid = 1; mem_resp_data = 32'h88;
        tick();
        mem_resp_valid = 0;
        chk("rw_m1_rv", m1_resp_valid, 1);
        chk("rw_m1_rd", m1_resp_data, 32'h88);
        chk("rw_m0_rv_end", m0_resp_valid, 0);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
